// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths, FSM states and correction constants for the BCD-to-binary converter.
package bcd_pkg;
  localparam int DIGITS = 3;
  localparam int BCD_W = 4 * DIGITS;
  localparam int BIN_W = 10;
  localparam int ITER = 10;
  localparam int CNT_W = 4;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  localparam logic [3:0] ADJ_TH = 4'd8;
  localparam logic [3:0] ADJ_SUB = 4'd3;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: reverse double-dabble nibble correction, subtract 3 (mod 16) when the value is 8 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= ADJ_TH) ? d_i - ADJ_SUB : d_i;
endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential 3-digit BCD to 10-bit binary converter using reverse double-dabble over ITER shifts.
module bcd_to_bin
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] bin,
  output logic             err
);
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_sh, bcd_adj;
  logic [BIN_W-1:0] sh_q, sh_d, bin_q, bin_d;
  logic             pend_q, pend_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  assign bcd_sh = {1'b0, bcd_q[BCD_W-1:1]};

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i(bcd_sh[4*i +: 4]),
      .d_o(bcd_adj[4*i +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    sh_d    = sh_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bin_d   = bin_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_SHIFT;
        bcd_d   = {hundreds, tens, ones};
        sh_d    = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        pend_d  = (hundreds > DIGIT_MAX) | (tens > DIGIT_MAX) | (ones > DIGIT_MAX);
      end
    end else begin
      bcd_d = bcd_adj;
      sh_d  = {bcd_q[0], sh_q[BIN_W-1:1]};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = pend_q;
        bin_d   = pend_q ? '0 : sh_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      sh_q    <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      sh_q    <= sh_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign bin  = bin_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: randomized and directed checks of bcd_to_bin against a decimal-arithmetic reference model.
module tb_bcd_to_bin;
  logic       clk, rst_n, start;
  logic [3:0] hundreds, tens, ones;
  logic       busy, done, err;
  logic [9:0] bin;
  int         n_chk = 0;
  int         n_pass = 0;
  time        last_done_t = 0;

  bcd_to_bin dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .busy(busy), .done(done), .bin(bin), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic bit ref_err(input int h, input int t, input int o);
    return (h > 9) || (t > 9) || (o > 9);
  endfunction

  function automatic int ref_bin(input int h, input int t, input int o);
    return ref_err(h, t, o) ? 0 : h * 100 + t * 10 + o;
  endfunction

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic convert(input int h, input int t, input int o, input int drop_at, input bit jitter);
    int n, bc;
    n = 0;
    bc = 0;
    start = 1'b1;
    hundreds = 4'(h);
    tens = 4'(t);
    ones = 4'(o);
    @(posedge clk);
    do begin
      @(negedge clk);
      n++;
      start = (n == drop_at);
      if (start) {hundreds, tens, ones} = 12'h777;
      else if (jitter) {hundreds, tens, ones} = 12'($urandom);
      if (busy) bc++;
    end while (!done && n < 25);
    start = 1'b0;
    last_done_t = $time;
    check("latency", n, 11);
    check("busy_cycles", bc, 10);
    check("busy_at_done", int'(busy), 0);
    check("bin", int'(bin), ref_bin(h, t, o));
    check("err", int'(err), int'(ref_err(h, t, o)));
  endtask

  task automatic no_done(input string tag, input int cycles);
    int extra;
    extra = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check(tag, extra, 0);
  endtask

  task automatic reset_mid(input int h, input int t, input int o, input int cyc);
    start = 1'b1;
    hundreds = 4'(h);
    tens = 4'(t);
    ones = 4'(o);
    @(posedge clk);
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_bin", int'(bin), 0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done("rst_no_done", 15);
  endtask

  initial begin
    int h, t, o;
    time t0;
    rst_n = 1'b1;
    start = 1'b0;
    {hundreds, tens, ones} = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("init_busy", int'(busy), 0);
    check("init_done", int'(done), 0);
    check("init_err", int'(err), 0);
    check("init_bin", int'(bin), 0);
    rst_n = 1'b1;
    @(negedge clk);
    convert(2, 5, 5, 0, 0);
    convert(9, 9, 9, 0, 0);
    convert(0, 0, 0, 0, 0);
    convert(1, 0, 0, 0, 0);
    convert(0, 10, 3, 0, 0);
    convert(0, 4, 2, 0, 0);
    convert(1, 2, 3, 4, 0);
    no_done("dropped_start", 15);
    reset_mid(6, 0, 0, 5);
    convert(0, 6, 4, 0, 0);
    convert(15, 0, 0, 0, 0);
    reset_mid(3, 3, 3, 2);
    convert(8, 0, 7, 0, 0);
    for (int k = 0; k < 200; k++) begin
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      convert(h, t, o, 0, 1);
    end
    for (int v = 0; v < 1000; v++) begin
      t0 = last_done_t;
      convert(v / 100, (v / 10) % 10, v % 10, 0, 0);
      if (v > 0) check("spacing", int'((last_done_t - t0) / 10), 11);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
